pe_out_formatter: RTL and testbench

- Output formatting stage directly downstream of the PE multiply-accumulate datapath.
- Takes the full-precision accumulator word: 2W bits, signed, 2*para_frac_bits fractional bits.
- Produces a W-bit signed fixed-point result in the PE operand format (para_int_bits.para_frac_bits), applying optional round-half-up and saturation.
- Two-stage valid/ready pipeline with backpressure, plus a sticky saturation flag and a saturation event counter for debug/status.

---
 rtl/pe_out_formatter.sv | 100 ++++++++++
 tb/tb_pe_out_formatter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_out_formatter.sv
// Output formatter behind the PE MAC: rounds/truncates a 2W-bit accumulator with 2F fraction
// bits down to a W-bit fixed-point word, saturating on overflow, through a 2-entry pipeline.
module pe_out_formatter #(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int sat_cnt_bits   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*(para_int_bits+para_frac_bits)-1:0] acc_data,
  input  logic                         acc_valid,
  output logic                         acc_ready,
  input  logic                         rounder_en,
  output logic [para_int_bits+para_frac_bits-1:0]     fmt_data,
  output logic                         fmt_valid,
  input  logic                         fmt_ready,
  output logic                         sat_flag,
  input  logic                         sat_clr,
  output logic [sat_cnt_bits-1:0]      sat_count
);

  localparam int W  = para_int_bits + para_frac_bits;
  localparam int F  = para_frac_bits;
  localparam int RW = 2 * W + 1;
  // Bits [2W:F+W-1] of r must all agree for the shifted value to fit in W signed bits.
  localparam int HB = W - F + 2;
  localparam logic [sat_cnt_bits-1:0] CNT_MAX = '1;

  logic          s1_valid;
  logic          s2_valid;
  logic [RW-1:0] s1_r;
  logic [RW-1:0] acc_ext;
  logic [RW-1:0] rnd_add;
  logic [HB-1:0] hi_bits;
  logic          sat_hit;
  logic [W-1:0]  sat_val;
  logic          s2_load;
  logic          acc_fire;
  logic          unused_low;

  // Handshake: a word moves on a rising edge where valid && ready; a producer holding valid
  // keeps its data stable, and acc_ready is derived only from pipeline occupancy, never acc_valid.
  assign s2_load   = s1_valid && (!s2_valid || fmt_ready);
  assign acc_ready = !s1_valid || s2_load;
  assign acc_fire  = acc_valid && acc_ready;
  assign fmt_valid = s2_valid;

  assign acc_ext = {acc_data[2*W-1], acc_data};
  assign rnd_add = rounder_en ? (RW'(1) << (F - 1)) : '0;

  // The fraction bits below F only matter through the rounding carry already folded into r.
  assign unused_low = ^s1_r[F-1:0];

  always_comb begin
    hi_bits = s1_r[RW-1 -: HB];
    sat_hit = !((&hi_bits) || (~|hi_bits));
    if (!sat_hit)
      sat_val = s1_r[F+W-1:F];
    else if (s1_r[RW-1])
      sat_val = {1'b1, {(W-1){1'b0}}};
    else
      sat_val = {1'b0, {(W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_r      <= '0;
      s2_valid  <= 1'b0;
      fmt_data  <= '0;
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else begin
      if (acc_fire) begin
        s1_r     <= acc_ext + rnd_add;
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        s2_valid <= 1'b1;
        fmt_data <= sat_val;
      end else if (fmt_ready) begin
        s2_valid <= 1'b0;
      end

      // Status tracks results as they enter S2; a same-cycle clear takes priority.
      if (sat_clr) begin
        sat_flag  <= 1'b0;
        sat_count <= '0;
      end else if (s2_load && sat_hit) begin
        sat_flag <= 1'b1;
        if (sat_count != CNT_MAX)
          sat_count <= sat_count + sat_cnt_bits'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_out_formatter.sv
// Bench for pe_out_formatter: directed vector table, backpressure/throughput/reset sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_pe_out_formatter;

  localparam int F = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] acc_data;
  logic        acc_valid;
  logic        acc_ready;
  logic        rounder_en;
  logic [15:0] fmt_data;
  logic        fmt_valid;
  logic        fmt_ready;
  logic        sat_flag;
  logic        sat_clr;
  logic [15:0] sat_count;

  pe_out_formatter dut (
    .clk        (clk),
    .rst        (rst),
    .acc_data   (acc_data),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .rounder_en (rounder_en),
    .fmt_data   (fmt_data),
    .fmt_valid  (fmt_valid),
    .fmt_ready  (fmt_ready),
    .sat_flag   (sat_flag),
    .sat_clr    (sat_clr),
    .sat_count  (sat_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  int          acc_t[$];
  int          out_t[$];
  int          ncyc  = 0;
  int          n_out = 0;
  int          m_sat = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  logic [15:0] m_e;
  logic        m_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: real-valued floor((acc + half) / 2^F), then clamp to the 16-bit signed range.
  function automatic void model(input logic [31:0] a, input logic rnd,
                                output logic [15:0] o, output logic s);
    longint v;
    longint q;
    v = longint'($signed(a)) + (rnd ? 64'sd256 : 64'sd0);
    q = v >>> F;
    s = 1'b0;
    if (q > 32767) begin
      o = 16'h7fff; s = 1'b1;
    end else if (q < -32768) begin
      o = 16'h8000; s = 1'b1;
    end else begin
      o = q[15:0];
    end
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      exp_q.delete();
      acc_t.delete();
      out_t.delete();
      m_sat      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", fmt_valid, 1);
        check("hold_data", fmt_data, prev_data);
      end
      if (fmt_valid && fmt_ready) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          check("out_data", fmt_data, m_e);
        end
        out_t.push_back(ncyc);
        n_out++;
      end
      if (sat_clr) m_sat = 0;
      if (acc_valid && acc_ready) begin
        model(acc_data, rounder_en, m_e, m_s);
        exp_q.push_back(m_e);
        acc_t.push_back(ncyc);
        if (m_s && m_sat < 65535) m_sat++;
      end
      prev_stall = fmt_valid && !fmt_ready;
      prev_data  = fmt_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic rnd);
    int i;
    acc_data   = a;
    rounder_en = rnd;
    acc_valid  = 1'b1;
    i = 0;
    @(negedge clk);
    while (!acc_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("send_accept", acc_ready, 1);
    step();
    acc_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    fmt_ready = 1'b1;
    i = 0;
    while ((exp_q.size() != 0 || fmt_valid) && i < 50) begin
      step();
      i++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("clr_flag", sat_flag, 0);
    check("clr_cnt", sat_count, 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] a;
    logic        rnd;
    logic        clr;
    logic [15:0] d;
    logic        f;
    logic [15:0] c;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int   k;
    int   n0;
    int   i;
    logic saw_low;
    logic taken;

    vecs[0]  = '{32'h0000_0300, 1'b0, 1'b0, 16'h0001, 1'b0, 16'd0};
    vecs[1]  = '{32'h0000_0300, 1'b1, 1'b0, 16'h0002, 1'b0, 16'd0};
    vecs[2]  = '{32'hFFFF_FF00, 1'b0, 1'b0, 16'hFFFF, 1'b0, 16'd0};
    vecs[3]  = '{32'hFFFF_FF00, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    vecs[4]  = '{32'h00FF_FE00, 1'b0, 1'b0, 16'h7FFF, 1'b0, 16'd0};
    vecs[5]  = '{32'hFF00_0000, 1'b0, 1'b0, 16'h8000, 1'b0, 16'd0};
    vecs[6]  = '{32'hFEFF_FFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 16'd0};
    vecs[7]  = '{32'h0100_0000, 1'b0, 1'b0, 16'h7FFF, 1'b1, 16'd1};
    vecs[8]  = '{32'h8000_0000, 1'b0, 1'b0, 16'h8000, 1'b1, 16'd2};
    vecs[9]  = '{32'hFEFF_FF00, 1'b0, 1'b1, 16'h8000, 1'b1, 16'd1};
    vecs[10] = '{32'h00FF_FF00, 1'b1, 1'b0, 16'h7FFF, 1'b1, 16'd2};
    vecs[11] = '{32'h00FF_FF00, 1'b0, 1'b0, 16'h7FFF, 1'b1, 16'd2};

    rst        = 1'b1;
    acc_data   = '0;
    acc_valid  = 1'b0;
    rounder_en = 1'b0;
    fmt_ready  = 1'b1;
    sat_clr    = 1'b0;
    #3;
    check("rst_fmt_valid", fmt_valid, 0);
    check("rst_fmt_data", fmt_data, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_sat_count", sat_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("rst_acc_ready", acc_ready, 1);

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].clr) pulse_clr();
      send(vecs[v].a, vecs[v].rnd);
      i = 0;
      @(negedge clk);
      while (!fmt_valid && i < 10) begin
        @(negedge clk);
        i++;
      end
      check($sformatf("vec%0d_valid", v), fmt_valid, 1);
      check($sformatf("vec%0d_data", v), fmt_data, vecs[v].d);
      check($sformatf("vec%0d_flag", v), sat_flag, vecs[v].f);
      check($sformatf("vec%0d_cnt", v), sat_count, vecs[v].c);
      step();
    end
    drain();

    // Backpressure: five back-to-back words, downstream stalled for cycles 2..5.
    n0 = n_out;
    saw_low = 1'b0;
    k = 1;
    for (int c = 0; c < 30; c++) begin
      fmt_ready  = (c < 2 || c > 5);
      acc_valid  = (k <= 5);
      acc_data   = k << 9;
      rounder_en = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!acc_ready) saw_low = 1'b1;
      if (acc_valid && acc_ready) k++;
      step();
    end
    acc_valid = 1'b0;
    drain();
    check("bp_ready_drop", saw_low, 1);
    check("bp_out_count", n_out - n0, 5);

    // Full throughput: eight words with fmt_ready held high.
    acc_t.delete();
    out_t.delete();
    for (int j = 0; j < 8; j++) begin
      acc_data   = $urandom;
      rounder_en = 1'($urandom_range(0, 1));
      acc_valid  = 1'b1;
      @(negedge clk);
      check("tp_ready", acc_ready, 1);
      step();
    end
    acc_valid = 1'b0;
    drain();
    check("tp_out_count", out_t.size(), 8);
    if (out_t.size() > 0 && acc_t.size() > 0)
      check("tp_latency", out_t[0], acc_t[0] + 2);
    for (int j = 1; j < out_t.size(); j++)
      check("tp_consec", out_t[j], out_t[0] + j);

    // Reset while both stages hold data and the output is stalled.
    pulse_clr();
    fmt_ready = 1'b0;
    send(32'h0100_0000, 1'b0);
    send(32'h0000_0400, 1'b0);
    check("pre_rst_valid", fmt_valid, 1);
    check("pre_rst_cnt", sat_count, 1);
    check("pre_rst_ready", acc_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", fmt_valid, 0);
    check("mid_rst_cnt", sat_count, 0);
    check("mid_rst_flag", sat_flag, 0);
    step();
    rst = 1'b0;
    fmt_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("no_stale", fmt_valid, 0);
    end
    step();
    check("post_rst_ready", acc_ready, 1);
    send(32'h0000_0A00, 1'b1);
    drain();
    check("post_rst_count", out_t.size(), 1);
    if (out_t.size() > 0 && acc_t.size() > 0)
      check("post_rst_latency", out_t[0], acc_t[0] + 2);

    // Randomized traffic with random backpressure.
    pulse_clr();
    taken = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!acc_valid || taken) begin
        acc_valid  = ($urandom_range(0, 3) != 0);
        rounder_en = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       acc_data = $urandom;
          1:       acc_data = 32'($urandom_range(0, 4095)) - 32'd2048;
          2:       acc_data = 32'h00FF_FE00 + 32'($urandom_range(0, 1023));
          default: acc_data = 32'hFEFF_FC00 + 32'($urandom_range(0, 1023));
        endcase
      end
      fmt_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      taken = acc_valid && acc_ready;
      step();
    end
    acc_valid = 1'b0;
    drain();
    check("rnd_sat_cnt", sat_count, m_sat);
    check("rnd_sat_flag", sat_flag, m_sat != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
